// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills instruction memory and releases the CPU
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest word count the memory can hold; the 16-bit header cannot exceed 2^16 anyway
    localparam logic [31:0] MAX_WORDS = (ADDR_WIDTH >= 16) ? 32'h0001_0000 : (32'd1 << ADDR_WIDTH);

    state_t      state;
    state_t      next_state;

    logic [7:0]  count_hi;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  csum;

    logic        transfer;
    logic [15:0] header_n;
    logic        last_word;

    assign transfer  = in_valid && in_ready;
    assign header_n  = {count_hi, in_data};
    assign last_word = ((word_idx + 16'd1) == word_count);

    // State register and registered in_ready derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_HDR_HI;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != S_DONE) && (next_state != S_ERROR);
        end
    end

    // Next-state decode; every state holds unless a byte is transferred
    always_comb begin
        next_state = state;
        case (state)
            S_HDR_HI: begin
                if (transfer) next_state = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (transfer) begin
                    if ({16'd0, header_n} > MAX_WORDS) next_state = S_ERROR;
                    else if (header_n == 16'd0)        next_state = S_CSUM;
                    else                               next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (transfer && (byte_cnt == 2'd3) && last_word) next_state = S_CSUM;
            end
            S_CSUM: begin
                if (transfer) next_state = (in_data == csum) ? S_DONE : S_ERROR;
            end
            default: next_state = state;
        endcase
    end

    // Header capture, word assembly, checksum accumulation and the one-cycle write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi   <= 8'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            csum       <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (transfer) begin
                case (state)
                    S_HDR_HI: count_hi   <= in_data;
                    S_HDR_LO: word_count <= header_n;
                    S_DATA: begin
                        shift    <= {shift[15:0], in_data};
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {shift, in_data};
                            mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status flags decoded straight from the terminal states
    always_comb begin
        done      = (state == S_DONE);
        error     = (state == S_ERROR);
        cpu_reset = (state != S_DONE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int total  = 0;
    int passed = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic        both_flags = 1'b0;

    typedef struct {
        string        name;
        int           len;
        logic [159:0] frame;
        int           n_wr;
        logic [127:0] words;
        logic         exp_done;
        logic         exp_error;
    } vec_t;

    vec_t vecs[7];

    imem_loader #(
        .ADDR_WIDTH (2),
        .BASE_ADDR  (32'h00000000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (done && error) both_flags = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL ready timeout: in_ready=0 for byte %h, required 1 within 20 cycles", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input int n, input logic [127:0] words);
        check({name, " write count"}, 32'(wr_addr.size()), 32'(n));
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            check($sformatf("%s addr[%0d]", name, k), wr_addr[k], 32'(4 * k));
            check($sformatf("%s data[%0d]", name, k), wr_data[k], words[32*(n-1-k) +: 32]);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, " in_ready"},  32'(in_ready),  32'd0);
        check({name, " mem_we"},    32'(mem_we),    32'd0);
        check({name, " mem_addr"},  mem_addr,       32'h0);
        check({name, " mem_wdata"}, mem_wdata,      32'h0);
        check({name, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, " done"},      32'(done),      32'd0);
        check({name, " error"},     32'(error),     32'd0);
    endtask

    initial begin
        logic [159:0] fr;
        logic [7:0]   nrm [11];
        logic         ready_seen;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Checksum of 20 08 00 05 AC 08 00 04 is 0x8D
        vecs[0] = '{"normal",   11, 160'h0002_20080005_AC080004_8D, 2, 128'h20080005_AC080004, 1'b1, 1'b0};
        vecs[1] = '{"empty",     3, 160'h0000_00,                    0, 128'h0,                1'b1, 1'b0};
        vecs[2] = '{"badcsum",  11, 160'h0002_20080005_AC080004_80, 2, 128'h20080005_AC080004, 1'b0, 1'b1};
        vecs[3] = '{"oneword",   7, 160'h0001_12345678_08,          1, 128'h12345678,          1'b1, 1'b0};
        vecs[4] = '{"fullmem",  19, 160'h0004_00000001_00000002_00000003_00000004_04, 4,
                    128'h00000001_00000002_00000003_00000004, 1'b1, 1'b0};
        vecs[5] = '{"oversize",  2, 160'h0005,                      0, 128'h0,                1'b0, 1'b1};
        vecs[6] = '{"emptybad",  3, 160'h0000_01,                   0, 128'h0,                1'b0, 1'b1};

        nrm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04, 8'h8D};

        @(negedge clk);
        @(negedge clk);
        check_reset_state("startup");
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            do_reset();
            fr = vecs[v].frame;
            for (int i = 0; i < vecs[v].len; i++) send_byte(fr[8*(vecs[v].len-1-i) +: 8], 0);
            repeat (3) @(negedge clk);
            check_writes(vecs[v].name, vecs[v].n_wr, vecs[v].words);
            check({vecs[v].name, " done"},      32'(done),      32'(vecs[v].exp_done));
            check({vecs[v].name, " error"},     32'(error),     32'(vecs[v].exp_error));
            check({vecs[v].name, " cpu_reset"}, 32'(cpu_reset), 32'(!vecs[v].exp_done));
            check({vecs[v].name, " in_ready"},  32'(in_ready),  32'd0);
        end

        // Write latency, done timing and refusal of trailing bytes
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        check("A mem_we latency", 32'(mem_we), 32'd1);
        check("A mem_addr",       mem_addr,    32'h0);
        check("A mem_wdata",      mem_wdata,   32'h12345678);
        check("A done before csum",      32'(done),      32'd0);
        check("A cpu_reset before csum", 32'(cpu_reset), 32'd1);
        send_byte(8'h08, 0);
        check("A mem_we one cycle",     32'(mem_we),    32'd0);
        check("A done after csum",      32'(done),      32'd1);
        check("A cpu_reset after csum", 32'(cpu_reset), 32'd0);
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        ready_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) ready_seen = 1'b1;
        end
        in_valid = 1'b0;
        check("A ready after done", 32'(ready_seen), 32'd0);
        check("A done sticky",      32'(done),       32'd1);
        check_writes("A", 1, 128'h12345678);

        // Oversize header flags error on the very next cycle
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        check("B error timing", 32'(error),     32'd1);
        check("B in_ready",     32'(in_ready),  32'd0);
        check("B done",         32'(done),      32'd0);
        check("B cpu_reset",    32'(cpu_reset), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("B error sticky", 32'(error), 32'd1);
        check_writes("B", 0, 128'h0);

        // Random valid gaps between bytes
        do_reset();
        for (int i = 0; i < 11; i++) send_byte(nrm[i], int'($urandom_range(0, 3)));
        repeat (3) @(negedge clk);
        check_writes("C gaps", 2, 128'h20080005_AC080004);
        check("C done",      32'(done),      32'd1);
        check("C cpu_reset", 32'(cpu_reset), 32'd0);

        // Reset after a full load restores every output
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_state("reload reset");
        reset = 1'b0;

        // Reset mid-load then a fresh frame
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(nrm[i], 0);
        check_writes("D partial", 1, 128'h20080005);
        do_reset();
        check("D done cleared", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        repeat (2) @(negedge clk);
        check_writes("D fresh", 1, 128'h12345678);
        check("D done", 32'(done), 32'd1);

        // Reset coinciding with a word's 4th byte suppresses the write
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        in_valid = 1'b1;
        in_data  = 8'h78;
        reset    = 1'b1;
        @(negedge clk);
        check("E mem_we suppressed", 32'(mem_we),   32'd0);
        check("E in_ready in reset", 32'(in_ready), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hEF, 0);
        send_byte(8'h01, 0);
        send_byte(8'h88, 0);
        repeat (2) @(negedge clk);
        check_writes("E", 1, 128'hABCDEF01);
        check("E done",  32'(done),  32'd1);
        check("E error", 32'(error), 32'd0);

        check("done/error exclusive", 32'(both_flags), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
